// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle main control FSM
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle MIPS-subset main control unit
module main_control_fsm
  import ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MEM_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired
);

  state_t             state_q, state_d;
  logic               illegal_q;
  logic [CNT_W-1:0]   retired_q;
  logic               mem_rdy;
  logic               retire;
  logic               bad_opcode;

  assign mem_rdy = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

  always_comb begin
    state_d    = state_q;
    bad_opcode = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            bad_opcode = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // An instruction retires when a completing state hands control back to FETCH.
  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && bad_opcode) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCS_ALU;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_rdy;
        pc_write  = mem_rdy;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = mem_rdy;
      end
      S_EXEC: alu_src_a = 1'b1;
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        pc_source     = PCS_ALUOUT;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_source = PCS_JUMP;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    // Reset holds every enable low, whatever state_q happens to be.
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PCS_ALU;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REGB;
    end
  end

  // alu_ctl is registered downstream, so alu_op looks one state ahead.
  always_comb begin
    alu_op = ALU_ADD;
    if (rst_n) begin
      case (state_d)
        S_EXEC:   alu_op = ALU_RTYPE;
        S_BRANCH: alu_op = ALU_SUB;
        default:  alu_op = ALU_ADD;
      endcase
    end
  end

  assign illegal_op    = illegal_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - scoreboard bench for main_control_fsm
module tb_main_control_fsm;

  typedef enum int {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } tst_t;

  typedef struct packed {
    logic        pcw;
    logic        pcwc;
    logic [1:0]  pcs;
    logic        iod;
    logic        mrd;
    logic        mwr;
    logic        irw;
    logic        m2r;
    logic        rdst;
    logic        rwr;
    logic        sa;
    logic [1:0]  sb;
    logic [1:0]  aop;
    logic        ill;
    logic [31:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [31:0] instr_retired;

  vec_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    stim_done = 1'b0;

  always #5 clk = ~clk;

  main_control_fsm #(.CNT_W(32), .MEM_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal_op(illegal_op), .instr_retired(instr_retired)
  );

  // Output table written straight from the state descriptions; alu_op uses the hand-given next state.
  function automatic vec_t expect_vec(input bit rst, input tst_t cur, input tst_t nxt,
                                      input bit mr, input int cnt, input bit ill);
    vec_t v;
    v = '0;
    v.cnt = cnt;
    v.ill = ill;
    if (!rst) return v;
    case (cur)
      FETCH:  begin v.mrd = 1; v.sb = 2'b01; v.irw = mr; v.pcw = mr; end
      DECODE: v.sb = 2'b11;
      MEMADR, ADDIEX: begin v.sa = 1; v.sb = 2'b10; end
      MEMRD:  begin v.iod = 1; v.mrd = 1; end
      MEMWB:  begin v.m2r = 1; v.rwr = 1; end
      MEMWR:  begin v.iod = 1; v.mwr = mr; end
      EXEC:   v.sa = 1;
      ALUWB:  begin v.rdst = 1; v.rwr = 1; end
      ADDIWB: v.rwr = 1;
      BRANCH: begin v.sa = 1; v.pcs = 2'b01; v.pcwc = 1; end
      JUMP:   begin v.pcs = 2'b10; v.pcw = 1; end
      default: ;
    endcase
    v.aop = (nxt == EXEC) ? 2'b10 : (nxt == BRANCH) ? 2'b01 : 2'b00;
    return v;
  endfunction

  task automatic step(input string nm, input bit rst, input logic [5:0] op, input bit mr,
                      input tst_t cur, input tst_t nxt, input int cnt, input bit ill);
    @(posedge clk);
    #1;
    rst_n     = rst;
    opcode    = op;
    mem_ready = mr;
    exp_q.push_back(expect_vec(rst, cur, nxt, mr, cnt, ill));
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    vec_t  act, e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               illegal_op, instr_retired};
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: actual=%h expected=%h", nm, act, e);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; opcode = 6'b0; mem_ready = 1'b0;
    @(posedge clk);
    step("reset_0", 0, 6'b000000, 0, FETCH, FETCH, 0, 0);
    step("reset_1", 0, 6'b000000, 0, FETCH, FETCH, 0, 0);
    // R-type
    step("r_fetch",  1, 6'b000000, 1, FETCH,  DECODE, 0, 0);
    step("r_decode", 1, 6'b000000, 1, DECODE, EXEC,   0, 0);
    step("r_exec",   1, 6'b000000, 1, EXEC,   ALUWB,  0, 0);
    step("r_aluwb",  1, 6'b000000, 1, ALUWB,  FETCH,  0, 0);
    // LW with fetch wait and three read wait cycles
    step("lw_fwait",  1, 6'b100011, 0, FETCH,  FETCH,  1, 0);
    step("lw_fetch",  1, 6'b100011, 1, FETCH,  DECODE, 1, 0);
    step("lw_decode", 1, 6'b100011, 1, DECODE, MEMADR, 1, 0);
    step("lw_memadr", 1, 6'b100011, 1, MEMADR, MEMRD,  1, 0);
    for (int i = 0; i < 3; i++)
      step("lw_rdwait", 1, 6'b100011, 0, MEMRD, MEMRD, 1, 0);
    step("lw_memrd",  1, 6'b100011, 1, MEMRD,  MEMWB,  1, 0);
    step("lw_memwb",  1, 6'b100011, 1, MEMWB,  FETCH,  1, 0);
    // SW
    step("sw_fetch",  1, 6'b101011, 1, FETCH,  DECODE, 2, 0);
    step("sw_decode", 1, 6'b101011, 1, DECODE, MEMADR, 2, 0);
    step("sw_memadr", 1, 6'b101011, 1, MEMADR, MEMWR,  2, 0);
    step("sw_wrwait", 1, 6'b101011, 0, MEMWR,  MEMWR,  2, 0);
    step("sw_memwr",  1, 6'b101011, 1, MEMWR,  FETCH,  2, 0);
    // BEQ then J
    step("beq_fetch",  1, 6'b000100, 1, FETCH,  DECODE, 3, 0);
    step("beq_decode", 1, 6'b000100, 1, DECODE, BRANCH, 3, 0);
    step("beq_branch", 1, 6'b000100, 1, BRANCH, FETCH,  3, 0);
    step("j_fetch",    1, 6'b000010, 1, FETCH,  DECODE, 4, 0);
    step("j_decode",   1, 6'b000010, 1, DECODE, JUMP,   4, 0);
    step("j_jump",     1, 6'b000010, 1, JUMP,   FETCH,  4, 0);
    // Illegal opcode, then reset in the middle of a LW
    step("ill_fetch",  1, 6'b111111, 1, FETCH,  DECODE, 5, 0);
    step("ill_decode", 1, 6'b111111, 1, DECODE, FETCH,  5, 0);
    step("ill_sticky", 1, 6'b100011, 1, FETCH,  DECODE, 5, 1);
    step("lw2_decode", 1, 6'b100011, 1, DECODE, MEMADR, 5, 1);
    step("lw2_memadr", 1, 6'b100011, 1, MEMADR, MEMRD,  5, 1);
    step("lw2_rst",    0, 6'b100011, 0, MEMRD,  FETCH,  5, 1);
    step("post_rst",   1, 6'b100011, 0, FETCH,  FETCH,  0, 0);
    // ADDI
    step("addi_fetch",  1, 6'b001000, 1, FETCH,  DECODE, 0, 0);
    step("addi_decode", 1, 6'b001000, 1, DECODE, ADDIEX, 0, 0);
    step("addi_ex",     1, 6'b001000, 1, ADDIEX, ADDIWB, 0, 0);
    step("addi_wb",     1, 6'b001000, 1, ADDIWB, FETCH,  0, 0);
    step("addi_done",   1, 6'b000000, 0, FETCH,  FETCH,  1, 0);
    stim_done = 1'b1;
  end

  initial begin : finisher
    int guard;
    guard = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual=%0d pending expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
